ram_cmd_arbiter: RTL and testbench

//  Shares the single-port SPI command RAM (10-bit {cmd[1:0],byte} word + rx_valid in; dout + tx_valid out)

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/ram_cmd_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================
// ram_arb_pkg - FSM state codes and RAM command codes. Rev 1.0
// ============================================================
`default_nettype none

package ram_arb_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 3'd0;
  localparam arb_state_t ST_WA   = 3'd1;
  localparam arb_state_t ST_WD   = 3'd2;
  localparam arb_state_t ST_RA   = 3'd3;
  localparam arb_state_t ST_RD   = 3'd4;
  localparam arb_state_t ST_RW   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================
// rr_arbiter - combinational round-robin pick after i_last. Rev 1.0
// ============================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  int              w_sum;
  logic [IDXW-1:0] w_cand;

  // Scan starts one past the previous winner and wraps, so the last winner has lowest priority.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = int'(i_last) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_cand = IDXW'(w_sum);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_cmd_arbiter.sv
// ============================================================
// ram_cmd_arbiter - round-robin sharing of the SPI command RAM. Rev 1.0
// ============================================================
`default_nettype none

module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ-1:0]           i_req_write,
  input  logic [NREQ*ADDR_SIZE-1:0] i_req_addr,
  input  logic [NREQ*MEM_WIDTH-1:0] i_req_wdata,
  output logic [NREQ-1:0]           o_rsp_valid,
  output logic [MEM_WIDTH-1:0]      o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [MEM_WIDTH+1:0]      o_ram_din,
  output logic                      o_ram_rx_valid,
  input  logic [MEM_WIDTH-1:0]      i_ram_dout,
  input  logic                      i_ram_tx_valid,
  output logic                      o_busy
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_t           r_state;
  logic [IDXW-1:0]      r_last;
  logic [IDXW-1:0]      r_gidx;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [MEM_WIDTH-1:0] r_wdata;
  logic [NREQ-1:0]      r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_rdata;
  logic                 r_rsp_err;

  logic [NREQ-1:0]      w_grant;
  logic [IDXW-1:0]      w_idx;
  logic                 w_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign o_req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDXW'(NREQ - 1);
      r_gidx      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_addr  <= i_req_addr[w_idx*ADDR_SIZE +: ADDR_SIZE];
            r_wdata <= i_req_wdata[w_idx*MEM_WIDTH +: MEM_WIDTH];
            r_gidx  <= w_idx;
            r_last  <= w_idx;
            r_state <= i_req_write[w_idx] ? ST_WA : ST_RA;
          end
        end
        ST_WA: r_state <= ST_WD;
        ST_WD: begin
          r_state             <= ST_IDLE;
          r_rsp_valid[r_gidx] <= 1'b1;
          r_rsp_rdata         <= '0;
          r_rsp_err           <= 1'b0;
        end
        ST_RA: r_state <= ST_RD;
        ST_RD: r_state <= ST_RW;
        ST_RW: begin
          // RAM read data appears one cycle after the RD_DATA word; a missing tx_valid flags an error.
          r_state             <= ST_IDLE;
          r_rsp_valid[r_gidx] <= 1'b1;
          r_rsp_rdata         <= i_ram_dout;
          r_rsp_err           <= ~i_ram_tx_valid;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ram_din      = '0;
    o_ram_rx_valid = 1'b0;
    case (r_state)
      ST_WA: begin
        o_ram_din      = {CMD_WR_ADDR, r_addr};
        o_ram_rx_valid = 1'b1;
      end
      ST_WD: begin
        o_ram_din      = {CMD_WR_DATA, r_wdata};
        o_ram_rx_valid = 1'b1;
      end
      ST_RA: begin
        o_ram_din      = {CMD_RD_ADDR, r_addr};
        o_ram_rx_valid = 1'b1;
      end
      ST_RD: begin
        o_ram_din      = {CMD_RD_DATA, {MEM_WIDTH{1'b0}}};
        o_ram_rx_valid = 1'b1;
      end
      default: begin
        o_ram_din      = '0;
        o_ram_rx_valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
// ============================================================
// tb_ram_cmd_arbiter - directed bench with a small SPI RAM model. Rev 1.0
// ============================================================
`default_nettype none

module tb_ram_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int MW   = 8;
  localparam int AS   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AS-1:0] req_addr;
  logic [NREQ*MW-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_valid;
  logic [MW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [MW+1:0]     ram_din;
  logic              ram_rx_valid;
  logic [MW-1:0]     ram_dout;
  logic              ram_tx_valid;
  logic              busy;

  always #5 clk = ~clk;

  ram_cmd_arbiter #(
    .NREQ      (NREQ),
    .MEM_WIDTH (MW),
    .ADDR_SIZE (AS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_ram_din      (ram_din),
    .o_ram_rx_valid (ram_rx_valid),
    .i_ram_dout     (ram_dout),
    .i_ram_tx_valid (ram_tx_valid),
    .o_busy         (busy)
  );

  // SPI RAM model: address latch, write, read with sticky tx_valid
  logic [7:0] mem [256];
  logic [7:0] m_addr = 8'h00;
  logic       no_tx = 1'b0;
  initial begin
    ram_dout     = '0;
    ram_tx_valid = 1'b0;
  end
  always @(posedge clk) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: begin m_addr <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        2'b01: begin mem[m_addr] <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        2'b10: begin m_addr <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        default: begin ram_dout <= mem[m_addr]; ram_tx_valid <= !no_tx; end
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    req_valid[i]       = v;
    req_write[i]       = w;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  function automatic int idx_of(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 9;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int t0;
  int ng, nr;
  int gi[6], gc[6], ri[6], rc[6], rd[6];
  logic found;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

    // Reset with req0 already requesting: ready must stay gated
    set_req(0, 1'b1, 1'b1, 8'h3C, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rxv",   32'(ram_rx_valid), 32'd0);
    chk("reset_din",   32'(ram_din), 32'd0);
    chk("reset_rspv",  32'(rsp_valid), 32'd0);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_err",   32'(rsp_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Write from req0
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'h1);
    t0 = cyc;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wr_word1", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h03C}));
    chk("wr_busy",  32'(busy), 32'd1);
    @(negedge clk);
    chk("wr_word2", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h1A5}));
    @(negedge clk);
    chk("wr_rspv",  32'(rsp_valid), 32'h1);
    chk("wr_rdata", 32'(rsp_rdata), 32'h0);
    chk("wr_err",   32'(rsp_err), 32'd0);
    chk("wr_lat",   32'(cyc - t0), 32'd3);
    chk("wr_idle",  32'(busy), 32'd0);

    // Read back from req1 in the same IDLE cycle
    set_req(1, 1'b1, 1'b0, 8'h3C, 8'h00);
    #1;
    chk("rd_ready", 32'(req_ready), 32'h2);
    t0 = cyc;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rd_word1", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h23C}));
    @(negedge clk);
    chk("rd_word2", 32'({ram_rx_valid, ram_din}), 32'({1'b1, 10'h300}));
    @(negedge clk);
    chk("rd_wait_rxv", 32'(ram_rx_valid), 32'd0);
    @(negedge clk);
    chk("rd_rspv",  32'(rsp_valid), 32'h2);
    chk("rd_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd_err",   32'(rsp_err), 32'd0);
    chk("rd_lat",   32'(cyc - t0), 32'd4);

    // Both requesters writing continuously: strict alternation
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 8'h10, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h22);
    @(negedge clk);
    ng = 0; nr = 0;
    for (int k = 0; k < 80; k++) begin
      if (ng < 6 && req_ready != 0) begin gi[ng] = idx_of(req_ready); gc[ng] = cyc; ng++; end
      if (nr < 6 && rsp_valid != 0) begin ri[nr] = idx_of(rsp_valid); nr++; end
      if (ng == 6 && nr == 6) break;
      @(posedge clk); #1;
      if (ng == 6) req_valid = '0;
      @(negedge clk);
    end
    chk("alt_count", 32'(ng * 10 + nr), 32'd66);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt_grant%0d", i), 32'(gi[i]), 32'(i % 2));
      chk($sformatf("alt_rsp%0d", i),   32'(ri[i]), 32'(i % 2));
    end
    chk("alt_spacing", 32'(gc[5] - gc[0]), 32'd15);
    chk("alt_mem10", 32'(mem[8'h10]), 32'h11);
    chk("alt_mem20", 32'(mem[8'h20]), 32'h22);

    // Back-to-back reads from req0
    @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    ng = 0; nr = 0;
    for (int k = 0; k < 40; k++) begin
      if (ng < 2 && req_ready != 0) begin gi[ng] = idx_of(req_ready); gc[ng] = cyc; ng++; end
      if (nr < 2 && rsp_valid != 0) begin
        ri[nr] = idx_of(rsp_valid); rc[nr] = cyc; rd[nr] = int'(rsp_rdata); nr++;
      end
      if (ng == 2 && nr == 2) break;
      @(posedge clk); #1;
      if (ng == 2) req_valid = '0;
      @(negedge clk);
    end
    chk("b2b_count", 32'(ng * 10 + nr), 32'd22);
    chk("b2b_grant1", 32'(gi[1]), 32'd0);
    chk("b2b_overlap", 32'(rc[0] - gc[1]), 32'd0);
    chk("b2b_gap", 32'(gc[1] - gc[0]), 32'd4);
    chk("b2b_rsp0", 32'(ri[0]), 32'd0);
    chk("b2b_rdata0", 32'(rd[0]), 32'h22);
    chk("b2b_rdata1", 32'(rd[1]), 32'h22);

    // RAM never asserts tx_valid: error response
    @(posedge clk); #1;
    no_tx = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("err_ready", 32'(req_ready), 32'h2);
    t0 = cyc;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin found = 1'b1; break; end
    end
    chk("err_found", 32'(found), 32'd1);
    chk("err_rspv",  32'(rsp_valid), 32'h2);
    chk("err_flag",  32'(rsp_err), 32'd1);
    chk("err_lat",   32'(cyc - t0), 32'd4);
    @(negedge clk);
    chk("err_idle",  32'(busy), 32'd0);
    chk("err_pulse", 32'(rsp_valid), 32'h0);
    chk("err_hold",  32'(rsp_err), 32'd1);
    no_tx = 1'b0;

    // Reset while in RD: transaction dropped, arbitration restarts at req0
    @(posedge clk); #1 set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ram_rx_valid && ram_din[9:8] == 2'b11) begin found = 1'b1; break; end
    end
    chk("rst_rd_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b1, 1'b1, 8'h30, 8'h33);
    @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rxv",   32'(ram_rx_valid), 32'd0);
    chk("rst_rspv0", 32'(rsp_valid), 32'h0);
    chk("rst_gate",  32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rst_rspv1", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
